// File: rtl/fetch_unit_pkg.sv
// Shared header for the fetch stage: word/field sizes, IR bit positions and FSM state encodings.
package fetch_unit_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned OP_SIZE   = 4;
    localparam int unsigned FUNC_SIZE = 6;
    localparam int unsigned REG_SIZE  = 2;
    localparam int unsigned IMM_SIZE  = 8;

    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RS_LSB   = 10;
    localparam int unsigned RT_LSB   = 8;
    localparam int unsigned RD_LSB   = 6;
    localparam int unsigned FUNC_LSB = 0;
    localparam int unsigned IMM_LSB  = 0;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake, redirect input and decoded-instruction output of the fetch stage.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 inputReady;
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_target;
    logic                 ir_valid;
    logic                 ir_ready;
    logic [OP_SIZE-1:0]   op;
    logic [REG_SIZE-1:0]  rs;
    logic [REG_SIZE-1:0]  rt;
    logic [REG_SIZE-1:0]  rd;
    logic [FUNC_SIZE-1:0] func;
    logic [IMM_SIZE-1:0]  imm;
    logic [WORD_SIZE-1:0] inst_pc;
    logic [WORD_SIZE-1:0] num_inst;

    modport master (
        output i_readM, i_address, ir_valid, op, rs, rt, rd, func, imm, inst_pc, num_inst,
        input  i_data, inputReady, redirect, redirect_target, ir_ready
    );

    modport slave (
        input  i_readM, i_address, ir_valid, op, rs, rt, rd, func, imm, inst_pc, num_inst,
        output i_data, inputReady, redirect, redirect_target, ir_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory, latches the IR and presents decoded
// fields until accepted. Redirects flush any in-flight fetch through a one-cycle FLUSH state.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] inst_pc_q, inst_pc_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

    // reset_n is high-true despite its name
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            inst_pc_q  <= '0;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            inst_pc_q  <= inst_pc_d;
            num_inst_q <= num_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        inst_pc_d  = inst_pc_q;
        num_inst_d = num_inst_q;

        unique case (state_q)
            StFetch: begin
                if (bus.inputReady && !bus.redirect) begin
                    ir_d      = bus.i_data;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + WORD_SIZE'(1);
                    state_d   = StHold;
                end
            end
            StHold: begin
                // Count the consumed instruction even if a redirect arrives on the same edge
                if (bus.ir_ready) begin
                    num_inst_d = num_inst_q + WORD_SIZE'(1);
                    state_d    = StFetch;
                end
            end
            StFlush: state_d = StFetch;
            default: state_d = StFetch;
        endcase

        if (bus.redirect) begin
            pc_d    = bus.redirect_target;
            state_d = StFlush;
        end
    end

    always_comb begin
        bus.i_readM   = (state_q == StFetch);
        bus.i_address = pc_q;
        bus.ir_valid  = (state_q == StHold);
        bus.op        = ir_q[OP_LSB +: OP_SIZE];
        bus.rs        = ir_q[RS_LSB +: REG_SIZE];
        bus.rt        = ir_q[RT_LSB +: REG_SIZE];
        bus.rd        = ir_q[RD_LSB +: REG_SIZE];
        bus.func      = ir_q[FUNC_LSB +: FUNC_SIZE];
        bus.imm       = ir_q[IMM_LSB +: IMM_SIZE];
        bus.inst_pc   = inst_pc_q;
        bus.num_inst  = num_inst_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random vs model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [15:0] data, input logic irr,
                         input logic redir, input logic [15:0] tgt);
        bus.inputReady      = rdy;
        bus.i_data          = data;
        bus.ir_ready        = irr;
        bus.redirect        = redir;
        bus.redirect_target = tgt;
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic [15:0] data;
        logic        irr;
        logic        redir;
        logic [15:0] tgt;
        logic        e_readm;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_num;
        logic [3:0]  e_op;
        logic [5:0]  e_func;
        logic [15:0] e_inst_pc;
    } vec_t;

    vec_t vecs[13];

    // Reference model: instruction-level view of the stage
    logic [15:0] m_pc, m_ir, m_inst_pc, m_num;
    bit          m_have, m_flushing;

    task automatic model_step(input logic rst);
        if (rst) begin
            m_pc = 16'h0000; m_ir = '0; m_inst_pc = '0; m_num = '0;
            m_have = 0; m_flushing = 0;
        end else if (bus.redirect) begin
            if (m_have && bus.ir_ready) m_num = m_num + 16'd1;
            m_pc = bus.redirect_target;
            m_have = 0;
            m_flushing = 1;
        end else if (m_flushing) begin
            m_flushing = 0;
        end else if (m_have) begin
            if (bus.ir_ready) begin
                m_num = m_num + 16'd1;
                m_have = 0;
            end
        end else if (bus.inputReady) begin
            m_ir = bus.i_data;
            m_inst_pc = m_pc;
            m_pc = m_pc + 16'd1;
            m_have = 1;
        end
    endtask

    logic [15:0] addrs_seen[$];

    initial begin
        logic [79:0] act, exp;
        logic [15:0] pk;

        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b1;
        do_reset();

        // Reset state
        check("reset_outputs",
              {bus.i_readM, bus.i_address, bus.ir_valid, bus.op, bus.rs, bus.rt, bus.rd,
               bus.func, bus.imm, bus.num_inst, bus.inst_pc},
              {1'b1, 16'h0000, 1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 6'd0, 8'd0, 16'd0, 16'd0});

        //          rdy   data     irr   redir tgt      readm addr     valid num    op    func  inst_pc
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 16'd0, 4'h0, 6'd0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 16'd0, 4'h0, 6'd0, 16'h0000};
        vecs[2]  = '{1'b1, 16'hF002, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0001, 1'b1, 16'd0, 4'hF, 6'd2, 16'h0000};
        for (int i = 3; i < 8; i++)
            vecs[i] = '{1'b1, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0001, 1'b1, 16'd0, 4'hF, 6'd2,
                        16'h0000};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, 16'd1, 4'hF, 6'd2, 16'h0000};
        vecs[9]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b0, 16'd1, 4'hF, 6'd2, 16'h0000};
        vecs[10] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0040, 1'b0, 16'd1, 4'hF, 6'd2, 16'h0000};
        vecs[11] = '{1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0041, 1'b1, 16'd1, 4'h3, 6'd0, 16'h0040};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0041, 1'b0, 16'd2, 4'h3, 6'd0, 16'h0040};

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].data, vecs[i].irr, vecs[i].redir, vecs[i].tgt);
            tick();
            check($sformatf("vec%0d", i),
                  {bus.i_readM, bus.i_address, bus.ir_valid, bus.num_inst, bus.op, bus.func,
                   bus.inst_pc},
                  {vecs[i].e_readm, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_num, vecs[i].e_op,
                   vecs[i].e_func, vecs[i].e_inst_pc});
        end

        // PC wrap at 16'hFFFF
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        check("wrap_fetch_addr", {bus.i_readM, bus.i_address}, {1'b1, 16'hFFFF});
        drive(1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0);
        tick();
        check("wrap_pc", {bus.ir_valid, bus.i_address, bus.inst_pc, bus.rs, bus.rt, bus.rd, bus.imm},
              {1'b1, 16'h0000, 16'hFFFF, 2'd2, 2'd3, 2'd3, 8'hCD});

        // Reset during HOLD overrides redirect and ir_ready
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0123);
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        check("reset_in_hold", {bus.i_readM, bus.i_address, bus.ir_valid, bus.num_inst},
              {1'b1, 16'h0000, 1'b0, 16'd0});

        // Redirect in HOLD together with ir_ready still counts the instruction
        drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200);
        tick();
        check("redirect_hold_count", {bus.i_readM, bus.ir_valid, bus.i_address, bus.num_inst},
              {1'b0, 1'b0, 16'h0200, 16'd1});

        // Single-cycle memory, ir_ready tied high: 4 instructions in 8 cycles
        do_reset();
        addrs_seen.delete();
        drive(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 8; c++) begin
            if (bus.i_readM) addrs_seen.push_back(bus.i_address);
            bus.i_data = 16'h1000 + bus.i_address;
            tick();
        end
        check("stream_num_inst", {64'd0, bus.num_inst}, {64'd0, 16'd4});
        check("stream_addr_count", 80'(addrs_seen.size()), 80'd4);
        for (int k = 0; k < addrs_seen.size() && k < 4; k++)
            check($sformatf("stream_addr%0d", k), {64'd0, addrs_seen[k]}, {64'd0, 16'(k)});

        // Randomized run against the reference model
        do_reset();
        model_step(1'b1);
        for (int c = 0; c < 500; c++) begin
            logic rst;
            rst = ($urandom_range(0, 63) == 0);
            pk  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), pk);
            reset_n = rst;
            model_step(rst);
            tick();
            reset_n = 1'b0;
            act = {6'd0, bus.i_readM, bus.i_address, bus.ir_valid, bus.op, bus.rs, bus.rt, bus.rd,
                   bus.func, bus.imm, bus.inst_pc, bus.num_inst};
            exp = {6'd0, !m_have && !m_flushing, m_pc, m_have, m_ir, m_ir[7:0], m_inst_pc, m_num};
            check($sformatf("random_cycle%0d", c), act, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle CPU, directly upstream of the control unit. It holds the PC, issues word reads to instruction memory over a request/ready handshake, and latches the returned word into the instruction register. It splits the register into `op`, `func` and operand fields and holds them valid until the downstream stage accepts. It redirects on taken branches and jumps, and discards any in-flight fetch when it does.

## Interface
Parameters:
- `WORD_SIZE`, 16, instruction, data and address width.
- `RESET_PC`, 16'h0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-high reset. The name follows codebase convention; the level is high-true.
- `i_readM`  out  1  memory read request.
- `i_address`  out  WORD_SIZE  read address; equal to `pc`.
- `i_data`  in  WORD_SIZE  read data; valid when `inputReady`=1.
- `inputReady`  in  1  memory response strobe.
- `redirect`  in  1  taken branch/jump from downstream.
- `redirect_target`  in  WORD_SIZE  new PC when `redirect`=1.
- `ir_valid`  out  1  decoded fields are valid.
- `ir_ready`  in  1  downstream accepts the current instruction.
- `op`  out  `OP_SIZE` (4)  IR[15:12].
- `rs`, `rt`, `rd`  out  2 each  IR[11:10], IR[9:8], IR[7:6].
- `func`  out  `FUNC_SIZE` (6)  IR[5:0].
- `imm`  out  8  IR[7:0].
- `inst_pc`  out  WORD_SIZE  address the current IR was fetched from.
- `num_inst`  out  WORD_SIZE  count of accepted instructions.

## Operation
States:
- **FETCH**:
  - `i_readM`=1 and `i_address`=`pc`.
  - On `inputReady`: IR←`i_data`, `inst_pc`←`pc`, `pc`←`pc`+1 (mod 2^WORD_SIZE), go to HOLD.
- **HOLD**:
  - `ir_valid`=1 and `i_readM`=0; fields are stable.
  - On `ir_ready`: `num_inst`+1 (wraps), go to FETCH.
- **FLUSH**:
  - One cycle; `i_readM`=0 and `ir_valid`=0.
  - Always goes to FETCH. This gives memory a clean request boundary.

Redirect (highest priority, any state):
- On `redirect`=1: `pc`←`redirect_target`, state←FLUSH, and `ir_valid` is 0 from the next cycle.
- In FETCH, a simultaneous `inputReady` is ignored: no IR load, no PC increment.
- In HOLD, a simultaneous `ir_ready` still increments `num_inst`, because the instruction was consumed.

Outputs:
- Fields are pure wire slices of IR; IR changes only on a FETCH load.
- `inputReady` outside FETCH is ignored.

Reset:
- State←FETCH, `pc`←RESET_PC, IR←0, `inst_pc`←0, `num_inst`←0.
- Consequently `ir_valid`=0, `op`=`func`=`rs`=`rt`=`rd`=`imm`=0, `i_readM`=1, `i_address`=RESET_PC from the first cycle after reset.
- Reset asserted mid-fetch or mid-hold overrides everything, including `redirect`.

## Timing
- `inputReady` sampled high at edge N → `ir_valid`=1 and `pc` advanced in cycle N+1.
- `ir_ready` high at edge M → `i_readM`=1 with the new address in cycle M+1. With single-cycle memory, throughput is one instruction per 2 cycles minimum.
- `redirect` at edge R → FLUSH in R+1 → `i_readM`=1 at `redirect_target` in R+2.
- `ir_valid` never drops without `ir_ready` or `redirect`.
- `i_address` never changes while `i_readM`=1 and no response has arrived, except through FLUSH.

## Structure
- `OP_SIZE`, `FUNC_SIZE` and `WORD_SIZE` come from the shared header.
- The shared header also gains the IR field bit positions and the state encodings (FETCH=0, HOLD=1, FLUSH=2).
- No sub-module: one FSM plus PC, IR and counter registers.

## Test plan
- Reset, then memory returns 16'hF002 after 2 cycles → `i_address`=0 during the wait; then `ir_valid`=1, `op`=4'hF, `func`=6'd2, `inst_pc`=0, `pc`=1.
- Hold `ir_ready`=0 for 5 cycles → outputs stable, `i_readM`=0. Then `ir_ready`=1 → `num_inst`=1 and next `i_address`=1.
- `redirect`=1 with target 16'h0040 in the same cycle as `inputReady` → IR unchanged and one FLUSH cycle with `i_readM`=0, then `i_address`=16'h0040.
- `pc`=16'hFFFF fetch completes → `pc` wraps to 16'h0000.
- Reset asserted during HOLD with `redirect`=1 → next cycle `pc`=RESET_PC, `ir_valid`=0, `num_inst`=0.
- Single-cycle memory, `ir_ready` tied high, 4 instructions → `num_inst`=4 after 8 cycles; addresses seen are 0, 1, 2, 3.
